shifter_cmd_sequencer: RTL and testbench
========================================

Name: shifter_cmd_sequencer

Overview:
Command sequencer directly upstream of shifter_8bit. It accepts {op, data, count} commands over a valid/ready interface and buffers them in a small FIFO. It drives the shifter's d_in/op/capture to apply one op `count` times back to back, feeding shifter d_out back to d_in each step. It then returns the final byte on a valid/ready result interface. While idle it holds the shifter frozen with capture=1.

Parameters:
CMD_DEPTH, 4, command FIFO depth (power of 2, >=2)
CNT_W, 4, width of repeat count (max steps 2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command FIFO not full
cmd_op  in  3  shifter op code
cmd_data  in  8  initial operand
cmd_count  in  CNT_W  number of shift steps
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  8  final shifted byte
busy  out  1  FSM not IDLE or FIFO non-empty
sh_d_in  out  8  to shifter d_in
sh_op  out  3  to shifter op
sh_capture  out  1  to shifter capture (1 = shifter holds)
sh_d_out  in  8  from shifter d_out (registered in shifter, 1-cycle latency)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Op codes: 000 shl1, 001 lsr1, 010 shl2, 011 lsr2, 100 rol1, 101 ror1, 110 hold. 111 is reserved: it is stored unchanged and issued to the shifter as 110.
- Reset values: FIFO empty, state IDLE, res_valid=0, res_data=0, sh_capture=1, sh_op=110, sh_d_in=0, busy=0, cmd_ready=1 after release.
- Command push: a command is written on the rising edge when cmd_valid && cmd_ready. cmd_ready = !full. There is no bypass; a push while full is ignored.
- FSM states:
  - IDLE: sh_capture=1, sh_op=110. If the FIFO is non-empty, pop on this edge. count==0 -> RESP with res_data<=data. count>0 -> RUN with step counter <= count and operand register <= data.
  - RUN: sh_capture=0, sh_op=op. sh_d_in = operand register on the first RUN cycle, otherwise sh_d_in = sh_d_out (combinational feedback). The step counter decrements each edge. The edge on which the counter reaches 0 moves to CAPT.
  - CAPT: sh_capture=1. res_data<=sh_d_out, then move to RESP.
  - RESP: res_valid=1, sh_capture=1. On res_valid && res_ready, move to IDLE with res_valid=0 next cycle.
- res_data is stable while res_valid=1 and res_ready=0.
- Latency: a command accepted at edge T into an empty FIFO with the FSM in IDLE is popped at T+1. res_valid rises after edge T+N+2 for N>0, and after T+1 for N=0.
- Throughput: one command per N+3 cycles (IDLE, N×RUN, CAPT, RESP minimum).
- Ordering: results are returned strictly in command order.
- Back-to-back pushes while running are queued. Push and pop on the same edge are legal; occupancy is unchanged.
- Reset mid-operation: all state clears asynchronously and queued or in-flight commands are dropped. sh_capture goes to 1 immediately. The shifter has no reset, so its d_out stays stale and is not used until a new RUN.
- cmd_* inputs are ignored during rst. Result data is never emitted for an aborted command.

Decomposition:
- Package shifter_pkg holds: op-code localparams (OP_SHL1 … OP_HOLD, OP_RSVD), the FSM state encoding, and the command struct width (3+8+CNT_W).
- Sub-module shifter_cmd_fifo: synchronous FIFO with parameterized depth, async active-high reset, and full/empty flags. Instantiated once.

Test Plan:
- shl1, data 11101110, count 1 -> res_data 11011100; res_valid high 3 cycles after accept.
- rol1, data 10010001, count 3 -> res_data 10001100; sh_capture low for exactly 3 cycles.
- lsr2, data 11101110, count 2 -> res_data 00001110. Then op 111, data 00111100, count 2 -> sh_op observed as 110, res_data 00111100.
- count 0, data 10100101 -> res_data 10100101, res_valid one cycle after pop; sh_capture never deasserted.
- Hold res_ready=0 and push 6 commands back to back -> 5 accepted (1 in FSM, 4 queued), cmd_ready=0 on the 6th. Release res_ready -> 5 results in order, then the 6th is accepted.
- Assert rst during RUN of ror1 ×8 -> same-cycle sh_capture=1, res_valid=0, busy=0, FIFO empty. No result appears after release.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op codes, FSM encoding and command sizing for the shifter command sequencer
// Purpose: op-code constants, sequencer state type, command word width helper and
//          the reserved-op remap used when issuing to the shifter.
// Ports:   none (package)
package shifter_pkg;

    localparam logic [2:0] OP_SHL1 = 3'b000;
    localparam logic [2:0] OP_LSR1 = 3'b001;
    localparam logic [2:0] OP_SHL2 = 3'b010;
    localparam logic [2:0] OP_LSR2 = 3'b011;
    localparam logic [2:0] OP_ROL1 = 3'b100;
    localparam logic [2:0] OP_ROR1 = 3'b101;
    localparam logic [2:0] OP_HOLD = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int CMD_OP_W   = 3;
    localparam int CMD_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } seq_state_t;

    // Packed command word is {op, data, count}.
    function automatic int cmd_width(input int cnt_w);
        return CMD_OP_W + CMD_DATA_W + cnt_w;
    endfunction

    // The reserved code is kept in the queue as-is but must never reach the shifter.
    function automatic logic [2:0] issue_op(input logic [2:0] op);
        return (op == OP_RSVD) ? OP_HOLD : op;
    endfunction

endpackage

// File: rtl/shifter_cmd_fifo.sv
// rtl/shifter_cmd_fifo.sv - synchronous command FIFO with full/empty flags
// Purpose: small first-word-fall-through queue holding packed commands.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wr_en, wr_data     push request and word (ignored when full)
//   rd_en, rd_data     pop request (ignored when empty) and head word
//   full, empty        occupancy flags
module shifter_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == FULL_CNT);
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/shifter_cmd_sequencer.sv
// rtl/shifter_cmd_sequencer.sv - queues shift commands and drives shifter_8bit through repeated steps
// Purpose: accepts {op, data, count} commands, applies op count times on the external
//          shifter with d_out fed back to d_in, and returns the final byte.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake; cmd_op, cmd_data, cmd_count payload
//   res_valid/res_ready, res_data     result handshake and final byte
//   busy                              sequencer active or commands pending
//   sh_d_in, sh_op, sh_capture        drive to shifter (capture=1 freezes it)
//   sh_d_out                          registered shifter output
module shifter_cmd_sequencer
    import shifter_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             busy,
    output logic [7:0]       sh_d_in,
    output logic [2:0]       sh_op,
    output logic             sh_capture,
    input  logic [7:0]       sh_d_out
);

    localparam int CMD_W = cmd_width(CNT_W);

    logic [CMD_W-1:0] w_wr_data;
    logic [CMD_W-1:0] w_rd_data;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_fifo_op;
    logic [7:0]       w_fifo_data;
    logic [CNT_W-1:0] w_fifo_count;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [2:0]       r_op;
    logic [7:0]       r_operand;
    logic [7:0]       r_res_data;
    logic [CNT_W-1:0] r_steps;
    logic             r_first;

    // Held low during reset so nothing is accepted while rst is asserted.
    assign cmd_ready = !rst && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_wr_data = {cmd_op, cmd_data, cmd_count};

    assign w_fifo_op    = w_rd_data[CMD_W-1 -: 3];
    assign w_fifo_data  = w_rd_data[CNT_W +: 8];
    assign w_fifo_count = w_rd_data[CNT_W-1:0];

    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign res_data = r_res_data;

    shifter_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Outputs are decoded from state only, so an async reset freezes the shifter at once.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        sh_capture  = 1'b1;
        sh_op       = OP_HOLD;
        sh_d_in     = 8'h00;
        res_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_fifo_count == '0) ? ST_RESP : ST_RUN;
                end
            end
            ST_RUN: begin
                sh_capture = 1'b0;
                sh_op      = issue_op(r_op);
                // First step loads the operand; later steps chain the shifter's own result.
                sh_d_in    = r_first ? r_operand : sh_d_out;
                if (r_steps == CNT_W'(1)) w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_HOLD;
            r_operand  <= 8'h00;
            r_res_data <= 8'h00;
            r_steps    <= '0;
            r_first    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_op      <= w_fifo_op;
                        r_operand <= w_fifo_data;
                        r_steps   <= w_fifo_count;
                        r_first   <= 1'b1;
                        if (w_fifo_count == '0) r_res_data <= w_fifo_data;
                    end
                end
                ST_RUN: begin
                    r_first <= 1'b0;
                    r_steps <= r_steps - 1'b1;
                end
                ST_CAPT: begin
                    r_res_data <= sh_d_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_cmd_sequencer.sv
// tb/tb_shifter_cmd_sequencer.sv - scoreboard bench for shifter_cmd_sequencer with a behavioural shifter
module tb_shifter_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic [7:0] sh_d_in;
    logic [2:0] sh_op;
    logic       sh_capture;
    logic [7:0] sh_d_out = 8'h00;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_res = 0;
    int         cap_low = 0;
    logic [2:0] last_op = 3'b000;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    shifter_cmd_sequencer #(.CMD_DEPTH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .sh_d_in    (sh_d_in),
        .sh_op      (sh_op),
        .sh_capture (sh_capture),
        .sh_d_out   (sh_d_out)
    );

    // Environment: shifter_8bit, registered output, frozen while capture=1, no reset.
    function automatic logic [7:0] shf(input logic [2:0] op, input logic [7:0] d);
        case (op)
            3'b000:  return {d[6:0], 1'b0};
            3'b001:  return {1'b0, d[7:1]};
            3'b010:  return {d[5:0], 2'b00};
            3'b011:  return {2'b00, d[7:2]};
            3'b100:  return {d[6:0], d[7]};
            3'b101:  return {d[0], d[7:1]};
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!sh_capture) sh_d_out <= shf(sh_op, sh_d_in);
    end

    always @(negedge clk) begin
        if (!sh_capture) begin
            cap_low = cap_low + 1;
            last_op = sh_op;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every result handshake against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_res++;
            if (sb.size() == 0) begin
                chk("unexpected_result", {24'h0, res_data}, 32'hFFFF_FFFF);
            end else begin
                chk("res_data", {24'h0, res_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] d, input logic [3:0] n,
                            input logic [7:0] exp);
        int k;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = n;
        cmd_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 300);
        if (!cmd_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back(exp);
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [7:0] d,
                           input logic [3:0] n, input logic [7:0] exp, input int exp_lat);
        int lat;
        int cl0;
        cl0 = cap_low;
        push_cmd(op, d, n, exp);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!res_valid && lat < 50);
        chk({tag, "_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        chk({tag, "_res_valid_drop"}, {31'h0, res_valid}, 32'd0);
        chk({tag, "_capture_low_cycles"}, cap_low - cl0, {28'h0, n});
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int r0;
        int vcnt;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 8'h00;
        cmd_count = 4'h0;
        res_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_res_valid",  {31'h0, res_valid},  32'd0);
        chk("rst_res_data",   {24'h0, res_data},   32'h0);
        chk("rst_sh_capture", {31'h0, sh_capture}, 32'd1);
        chk("rst_sh_op",      {29'h0, sh_op},      32'd6);
        chk("rst_sh_d_in",    {24'h0, sh_d_in},    32'h0);
        chk("rst_busy",       {31'h0, busy},       32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_cmd_ready",  {31'h0, cmd_ready},  32'd1);
        @(posedge clk);
        #1;

        run_one("shl1x1", 3'b000, 8'b11101110, 4'd1, 8'b11011100, 3);
        run_one("rol1x3", 3'b100, 8'b10010001, 4'd3, 8'b10001100, 5);
        run_one("lsr2x2", 3'b011, 8'b11101110, 4'd2, 8'b00001110, 4);
        chk("lsr2_op_seen", {29'h0, last_op}, 32'd3);
        run_one("rsvdx2", 3'b111, 8'b00111100, 4'd2, 8'b00111100, 4);
        chk("rsvd_op_as_hold", {29'h0, last_op}, 32'd6);
        run_one("cnt0",   3'b101, 8'b10100101, 4'd0, 8'b10100101, 1);
        chk("idle_busy", {31'h0, busy}, 32'd0);

        // Back-pressure: one command parks in RESP, four fill the queue, sixth is refused.
        res_ready = 1'b0;
        r0 = n_res;
        push_cmd(3'b000, 8'h01, 4'd1, 8'h02);
        push_cmd(3'b001, 8'h80, 4'd1, 8'h40);
        push_cmd(3'b110, 8'h5A, 4'd2, 8'h5A);
        push_cmd(3'b101, 8'h01, 4'd1, 8'h80);
        push_cmd(3'b010, 8'h03, 4'd0, 8'h03);
        cmd_op    = 3'b100;
        cmd_data  = 8'h80;
        cmd_count = 4'd2;
        cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        chk("held_res_valid", {31'h0, res_valid}, 32'd1);
        chk("held_res_data",  {24'h0, res_data},  32'h02);
        chk("held_busy",      {31'h0, busy},      32'd1);
        res_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 300);
        chk("sixth_accepted", {31'h0, cmd_ready}, 32'd1);
        if (cmd_ready) sb.push_back(8'h02);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        chk("bp_results", n_res - r0, 32'd6);
        chk("bp_drained", sb.size(), 32'd0);

        // Reset during a long run with a second command still queued.
        push_cmd(3'b101, 8'h01, 4'd8, 8'h01);
        push_cmd(3'b000, 8'h11, 4'd1, 8'h22);
        k = 0;
        while (sh_capture && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("abort_in_run", {31'h0, sh_capture}, 32'd0);
        @(negedge clk);
        chk("abort_busy_before", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sh_capture", {31'h0, sh_capture}, 32'd1);
        chk("abort_res_valid",  {31'h0, res_valid},  32'd0);
        chk("abort_busy",       {31'h0, busy},       32'd0);
        chk("abort_sh_op",      {29'h0, sh_op},      32'd6);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        r0 = n_res;
        repeat (30) begin
            @(negedge clk);
            if (res_valid || !sh_capture) vcnt++;
        end
        chk("abort_no_activity", vcnt, 32'd0);
        chk("abort_no_result", n_res - r0, 32'd0);
        chk("abort_cmd_ready", {31'h0, cmd_ready}, 32'd1);

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
